// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scan controller: an iterative double-dabble converter
// loads a BCD display register that a tick-driven scan multiplexes onto the commons.
module fnd_scan_controller #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_valid,
    input  logic        i_blankLZ,
    input  logic [3:0]  i_dotMask,
    output logic        o_ready,
    output logic [3:0]  o_digitValue,
    output logic        o_dp,
    output logic [3:0]  o_fndCom
);

    localparam int TICK_PERIOD = CLK_FREQ / SCAN_HZ;
    localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_PERIOD - 1);
    localparam logic [TICK_W-1:0] BLANK_LIMIT = TICK_W'(BLANK_CYCLES);
    localparam logic [13:0] VALUE_MAX = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } convState_t;

    convState_t        convState_r;
    logic [13:0]       bin_r;
    logic [15:0]       bcd_r;
    logic [3:0]        bitCnt_r;
    logic              ready_r;
    logic [15:0]       display_r;
    logic [TICK_W-1:0] tickCnt_r;
    logic [1:0]        scanIdx_r;
    logic [3:0]        digit_r;
    logic              dp_r;
    logic [3:0]        fndCom_r;

    logic              tickWrap_s;
    logic [TICK_W-1:0] tickNext_s;
    logic [1:0]        scanIdxNext_s;
    logic [15:0]       displayNext_s;
    logic [15:0]       bcdAdj_s;

    function automatic logic [15:0] add3Nibbles(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end else begin
                res[n*4 +: 4] = bcd[n*4 +: 4];
            end
        end
        return res;
    endfunction

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never blanks.
    function automatic logic [3:0] digitCode(input logic [15:0] bcd, input logic [1:0] idx,
                                             input logic blankLZ);
        logic [3:0] nib;
        logic       lz;
        case (idx)
            2'd0:    begin nib = bcd[3:0];   lz = 1'b0;                  end
            2'd1:    begin nib = bcd[7:4];   lz = (bcd[15:4]  == 12'd0); end
            2'd2:    begin nib = bcd[11:8];  lz = (bcd[15:8]  == 8'd0);  end
            2'd3:    begin nib = bcd[15:12]; lz = (bcd[15:12] == 4'd0);  end
            default: begin nib = 4'hF;       lz = 1'b0;                  end
        endcase
        return (blankLZ && lz) ? 4'hF : nib;
    endfunction

    // Next-state forwarding for scan position and display contents.
    always_comb begin
        tickWrap_s = (tickCnt_r == TICK_LAST);
        if (tickWrap_s) begin
            tickNext_s    = {TICK_W{1'b0}};
            scanIdxNext_s = scanIdx_r + 2'd1;
        end else begin
            tickNext_s    = tickCnt_r + TICK_W'(1);
            scanIdxNext_s = scanIdx_r;
        end
        if (convState_r == COMMIT) begin
            displayNext_s = bcd_r;
        end else begin
            displayNext_s = display_r;
        end
        bcdAdj_s = add3Nibbles(bcd_r);
    end

    // Converter FSM and display register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            convState_r <= IDLE;
            bin_r       <= 14'd0;
            bcd_r       <= 16'd0;
            bitCnt_r    <= 4'd0;
            ready_r     <= 1'b1;
            display_r   <= 16'd0;
        end else begin
            case (convState_r)
                IDLE: begin
                    if (i_valid) begin
                        bin_r       <= (i_value > VALUE_MAX) ? VALUE_MAX : i_value;
                        bcd_r       <= 16'd0;
                        bitCnt_r    <= 4'd14;
                        ready_r     <= 1'b0;
                        convState_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {bcdAdj_s[14:0], bin_r, 1'b0};
                    bitCnt_r       <= bitCnt_r - 4'd1;
                    if (bitCnt_r == 4'd1) begin
                        convState_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    display_r   <= displayNext_s;
                    ready_r     <= 1'b1;
                    convState_r <= IDLE;
                end
                default: begin
                    ready_r     <= 1'b1;
                    convState_r <= IDLE;
                end
            endcase
        end
    end

    // Scan counter plus registered commons, digit code and DP.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tickCnt_r <= {TICK_W{1'b0}};
            scanIdx_r <= 2'd0;
            fndCom_r  <= 4'hF;
            digit_r   <= 4'hF;
            dp_r      <= 1'b1;
        end else begin
            tickCnt_r <= tickNext_s;
            scanIdx_r <= scanIdxNext_s;
            fndCom_r  <= (tickNext_s < BLANK_LIMIT) ? 4'hF : ~(4'b0001 << scanIdxNext_s);
            if (tickWrap_s) begin
                digit_r <= digitCode(displayNext_s, scanIdxNext_s, i_blankLZ);
                dp_r    <= ~i_dotMask[scanIdxNext_s];
            end
        end
    end

    assign o_ready      = ready_r;
    assign o_digitValue = digit_r;
    assign o_dp         = dp_r;
    assign o_fndCom     = fndCom_r;

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Drives a 4-digit common-anode FND from a 14-bit binary value.
- Converts the value to BCD with an iterative double-dabble sequencer and time-multiplexes the digits with a tick-driven scan counter.
- Feeds a 4-bit code per digit into the existing BCD-to-7-segment font decoder.
- Inside the decoder's font table, code 4'hF means blank (font 8'hFF) and code 4'hA means dot-only.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- SCAN_HZ, 1000: digit-advance rate in Hz. Full frame rate = SCAN_HZ/4.
- BLANK_CYCLES, 16: cycles all commons stay off after each digit switch (anti-ghosting). Must be less than CLK_FREQ/SCAN_HZ.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_value  input  14  binary value to display; values >9999 clamp to 9999
- i_valid  input  1  load strobe; accepted only when o_ready=1
- i_blankLZ  input  1  1 = blank leading zeros
- i_dotMask  input  4  bit n=1 lights the DP on digit n (digit 0 = rightmost)
- o_ready  output  1  converter idle, can accept i_valid
- o_digitValue  output  4  code to the font decoder: 0-9, or 4'hF for blank
- o_dp  output  1  active-low DP for the selected digit; top level ANDs it into font bit 7
- o_fndCom  output  4  active-low digit commons, one-hot-low or all-high

Behaviour:
Reset, asynchronous and taking effect immediately:
- o_fndCom=4'hF, o_digitValue=4'hF, o_dp=1, o_ready=1.
- Display BCD register=0, scan index=0, tick counter=0, converter in IDLE.

Converter FSM, states IDLE, SHIFT, COMMIT:
- IDLE: on i_valid with o_ready=1, latch min(i_value, 9999) and a 16-bit BCD accumulator of 0. Set bit count=14, drop o_ready, go to SHIFT.
- i_valid while o_ready=0 is ignored. No queuing.
- SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1 and decrement the count. After 14 cycles go to COMMIT.
- COMMIT: copy the accumulator into the display register in one cycle (atomic, all 4 digits together). Raise o_ready and go to IDLE.
- Latency from the accepting edge to the display update is 15 cycles. o_ready is high again 15 cycles after acceptance, so back-to-back loads are possible every 15 cycles.

Scan:
- Tick counter counts 0..(CLK_FREQ/SCAN_HZ - 1) and wraps.
- On wrap, the scan index advances 0→1→2→3→0.
- When the counter value is below BLANK_CYCLES, o_fndCom=4'hF. Otherwise o_fndCom = ~(4'b0001 << index).
- o_digitValue and o_dp are registered from the current index and display register. They update on the same edge the index changes, so they are stable before the commons turn on.

Leading-zero blanking (i_blankLZ=1):
- Digit n is blank (4'hF) if it and every higher digit are 0. Digit 0 is never blanked.
- Example: value 7 shows "   7"; value 0 shows "   0".
- With i_blankLZ=0, all digits show numerically.

DP:
- o_dp = ~i_dotMask[index]. It applies even on a blanked digit.
- i_blankLZ and i_dotMask are sampled live each digit slot and are not latched at load.

Simultaneous events:
- A COMMIT that coincides with a scan-index advance: the new digit shows the new data. The display register write and the output register read use next-state forwarding.

Reset mid-conversion:
- Aborts the conversion, clears the display to 0, returns to IDLE.

Test Plan:
Bench parameters: CLK_FREQ=1000, SCAN_HZ=100 (10 cycles per digit), BLANK_CYCLES=2.
1. Reset → o_fndCom=F, o_digitValue=F, o_dp=1, o_ready=1. After release, the slot-0 commons read F for 2 cycles, then 4'b1110.
2. Load 1234 with i_blankLZ=0 → o_ready low for exactly 15 cycles. The next frame shows codes 4, 3, 2, 1 on indices 0-3, with o_fndCom E, D, B, 7 in order and F during the first 2 cycles of each slot.
3. Load 12000 → clamped to 9999, all four digits show 9.
4. Load 7 with i_blankLZ=1 → codes 7, F, F, F. Then load 0 → codes 0, F, F, F. With i_blankLZ=0 → 0, 0, 0, 0.
5. Pulse i_valid 5 cycles after a load → ignored; the display holds the first value. i_dotMask=4'b0100 → o_dp=0 only in slot 2.
6. Assert i_reset during SHIFT cycle 7 → immediate reset values, display 0. A subsequent load of 42 shows codes 2, 4, 0, 0 correctly.
